// File: rtl/controller.sv
// Multi-cycle RV32 subset control FSM (FETCH/DECODE/EXECUTE/MEM/WB/TRAP); BEQ/BNE enabled by CTRL_BRANCH_EN.
// Latency: 4 cycles R/I/LUI/SW, 5 LW, 3 branch at zero wait states; FETCH and MEM stall with stable bus until mem_ack.
module controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  rs_1,
    output logic [4:0]  rs_2,
    output logic [4:0]  rd_0,
    output logic [31:0] immediate,
    output logic        alu_source,
    output logic [2:0]  alu_control,
    output logic        write_rb,
    output logic [31:0] writedata,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic        negative,
    input  logic        overflow,
    input  logic        zero,
    output logic        illegal
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
                           ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111;

    state_t      state, next_state;
    logic [31:0] pc, ir, aluout, mdr;
    logic        run, illegal_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_lw, is_sw, is_lui, is_br, r_ok, i_ok, legal;
    logic [2:0]  f3_op;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);
    assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_lui = (opcode == 7'b0110111);
    assign is_br  = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);

    // SLTU (funct3=011) and SRA are outside the supported set
    assign r_ok = ((funct7 == 7'b0000000) && (funct3 != 3'b011)) ||
                  ((funct7 == 7'b0100000) && (funct3 == 3'b000));
    assign i_ok = funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};

`ifdef CTRL_BRANCH_EN
    logic br_taken;
    assign br_taken = (funct3 == 3'b000) ? zero : !zero;
    assign legal = (is_r && r_ok) || (is_i && i_ok) || is_lw || is_sw || is_lui || is_br;
`else
    assign legal = (is_r && r_ok) || (is_i && i_ok) || is_lw || is_sw || is_lui;
`endif

    logic unused_flags;
    assign unused_flags = ^{negative, overflow, zero};

    always_comb begin
        case (funct3)
            3'b000:  f3_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_op = ALU_ADD;
        endcase
    end

    assign rs_1        = is_lui ? 5'd0 : ir[19:15];
    assign rs_2        = ir[24:20];
    assign rd_0        = ir[11:7];
    assign alu_source  = is_r || is_br;
    assign alu_control = (is_r || is_i) ? f3_op : (is_br ? ALU_SUB : ALU_ADD);
    assign illegal     = illegal_q;

    always_comb begin
        if (is_sw)       immediate = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        else if (is_br)  immediate = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        else if (is_lui) immediate = {ir[31:12], 12'b0};
        else             immediate = {{20{ir[31]}}, ir[31:20]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:   if (run && mem_ack) next_state = S_DECODE;
            S_DECODE:  next_state = legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (is_lw || is_sw) next_state = (alu_result[1:0] != 2'b00) ? S_TRAP : S_MEM;
                else if (is_br)     next_state = S_FETCH;
                else                next_state = S_WB;
            end
            S_MEM:     if (mem_ack) next_state = is_sw ? S_FETCH : S_WB;
            S_WB:      next_state = S_FETCH;
            S_TRAP:    next_state = S_TRAP;
            default:   next_state = S_FETCH;
        endcase
    end

    // run holds off the first fetch until one edge after reset release
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        write_rb  = 1'b0;
        writedata = is_lw ? mdr : aluout;
        case (state)
            S_FETCH: if (run) begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = aluout;
                if (is_sw) begin
                    mem_we    = 1'b1;
                    mem_wdata = rs2_data;
                end
            end
            S_WB:    write_rb = (rd_0 != 5'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= 32'h0;
            aluout    <= 32'h0;
            mdr       <= 32'h0;
            run       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            run <= 1'b1;
            if (next_state == S_TRAP) illegal_q <= 1'b1;
            case (state)
                S_FETCH: if (run && mem_ack) ir <= mem_rdata;
                S_EXECUTE: begin
                    aluout <= alu_result;
`ifdef CTRL_BRANCH_EN
                    if (is_br) pc <= br_taken ? pc + immediate : pc + 32'd4;
`endif
                end
                S_MEM: if (mem_ack) begin
                    if (is_sw) pc  <= pc + 32'd4;
                    else       mdr <= mem_rdata;
                end
                S_WB:    pc <= pc + 32'd4;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_controller.sv
// Directed bench: memory + ALU + register-file model around the controller, scoreboarded bus and writeback.
module tb_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ack, alu_source, write_rb, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, immediate, writedata, alu_result, rs2_data;
    logic [4:0]  rs_1, rs_2, rd_0;
    logic [2:0]  alu_control;
    logic        negative, overflow, zero;

    always #5 clk = ~clk;

    controller dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rs_1(rs_1), .rs_2(rs_2),
        .rd_0(rd_0), .immediate(immediate), .alu_source(alu_source), .alu_control(alu_control),
        .write_rb(write_rb), .writedata(writedata), .alu_result(alu_result), .rs2_data(rs2_data),
        .negative(negative), .overflow(overflow), .zero(zero), .illegal(illegal)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;

    bus_t        bus_q[$];
    wb_t         wb_q[$];
    logic [31:0] memarr [logic [31:0]];
    logic [31:0] regs [32];
    logic [31:0] op_a, op_b;

    int          n_tests = 0, n_fail = 0, cyc = 0, first_wb_cyc = 0, wait_cnt = 0;
    logic        ack_override = 1'b0, mem_hold = 1'b0, hold_valid = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;

    // Environment ALU and register file feeding the controller
    always_comb begin
        op_a       = regs[rs_1];
        op_b       = alu_source ? regs[rs_2] : immediate;
        alu_result = 32'h0;
        case (alu_control)
            3'b000: alu_result = op_a + op_b;
            3'b001: alu_result = op_a - op_b;
            3'b010: alu_result = op_a & op_b;
            3'b011: alu_result = op_a | op_b;
            3'b100: alu_result = op_a ^ op_b;
            3'b101: alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            3'b110: alu_result = op_a << op_b[4:0];
            3'b111: alu_result = op_a >> op_b[4:0];
            default: alu_result = 32'h0;
        endcase
        zero     = (alu_result == 32'h0);
        negative = alu_result[31];
        overflow = 1'b0;
        rs2_data = regs[rs_2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        bus_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
    endtask
    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back('{we: 1'b1, addr: a, wdata: d});
    endtask
    task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
        wb_q.push_back('{rd: r, data: d});
    endtask

    // One cycle: memory responds at negedge, monitors compare against the scoreboard
    task automatic tick();
        bus_t e;
        wb_t  w;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            mem_ack    = ack_override;
            hold_valid = 1'b0;
            wait_cnt   = 0;
        end else begin
            if (hold_valid) begin
                chk("hold_req", mem_req, 1);
                chk("hold_we", mem_we, p_we);
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_wdata", mem_wdata, p_wdata);
            end
            if (ack_override) begin
                mem_ack = 1'b1;
            end else if (mem_req && !mem_hold && wait_cnt >= ((mem_addr == slow_addr) ? 3 : 0)) begin
                mem_ack   = 1'b1;
                wait_cnt  = 0;
                mem_rdata = memarr.exists(mem_addr) ? memarr[mem_addr] : 32'h0;
                n_tests++;
                assert (bus_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL bus_unexpected: got addr %h we %b expected no request", mem_addr, mem_we);
                end
                if (bus_q.size() != 0) begin
                    e = bus_q.pop_front();
                    chk("bus_we", mem_we, e.we);
                    chk("bus_addr", mem_addr, e.addr);
                    if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = mem_req ? wait_cnt + 1 : 0;
            end
            hold_valid = mem_req && !mem_ack;
            p_we    = mem_we;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            if (write_rb) begin
                n_tests++;
                assert (wb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL wb_unexpected: got rd %0d data %h expected no write", rd_0, writedata);
                end
                if (wb_q.size() != 0) begin
                    w = wb_q.pop_front();
                    chk("wb_rd", rd_0, w.rd);
                    chk("wb_data", writedata, w.data);
                end
                if (first_wb_cyc == 0) first_wb_cyc = cyc;
                if (rd_0 != 5'd0) regs[rd_0] = writedata;
            end
        end
    endtask

    task automatic enter_reset();
        #1 rst_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        first_wb_cyc = 0;
    endtask

    task automatic run_to_trap(input int bound);
        int k = 0;
        while (illegal !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        chk("trap_reached", illegal, 1);
        repeat (4) begin
            tick();
            chk("trap_req", mem_req, 0);
            chk("trap_wrb", write_rb, 0);
            chk("trap_illegal", illegal, 1);
        end
        chk("bus_q_left", bus_q.size(), 0);
        chk("wb_q_left", wb_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;

        // Reset values
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wrb", write_rb, 0);
        chk("rst_wdat", writedata, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_imm", immediate, 0);
        chk("rst_regaddr", {rs_1, rs_2, rd_0}, 0);
        tick();
        tick();

        // Early ack before the first edge must be ignored; then abort a stalled fetch with reset
        ack_override = 1'b1;
        mem_hold = 1'b1;
        tick();
        chk("rst_req_with_ack", mem_req, 0);
        #2 rst_n = 1'b1;
        #1 chk("req_before_edge", mem_req, 0);
        @(posedge clk);
        ack_override = 1'b0;
        repeat (3) begin
            tick();
            chk("fetch_wait_req", mem_req, 1);
            chk("fetch_wait_addr", mem_addr, 32'h0);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_illegal", illegal, 0);
        mem_hold = 1'b0;
        tick();
        tick();

        // Main program: ALU ops, SW, rd=x0, LUI, SLTI, then branch at 0x20
        memarr.delete();
        memarr[32'h00] = 32'h002081B3;  // ADD  x3,x1,x2
        memarr[32'h04] = 32'h40110333;  // SUB  x6,x2,x1
        memarr[32'h08] = 32'h08302023;  // SW   x3,128(x0)
        memarr[32'h0C] = 32'h00500013;  // ADDI x0,x0,5
        memarr[32'h10] = 32'h123453B7;  // LUI  x7,0x12345
        memarr[32'h14] = 32'h0060A413;  // SLTI x8,x1,6
        memarr[32'h18] = 32'h0020C4B3;  // XOR  x9,x1,x2
        memarr[32'h1C] = 32'h0020F533;  // AND  x10,x1,x2
        memarr[32'h20] = 32'h00108863;  // BEQ  x1,x1,+16
        memarr[32'h30] = 32'h00109863;  // BNE  x1,x1,+16
        push_rd(32'h00); push_wb(5'd3, 32'd12);
        push_rd(32'h04); push_wb(5'd6, 32'd2);
        push_rd(32'h08); push_wr(32'h80, 32'd12);
        push_rd(32'h0C);
        push_rd(32'h10); push_wb(5'd7, 32'h1234_5000);
        push_rd(32'h14); push_wb(5'd8, 32'd1);
        push_rd(32'h18); push_wb(5'd9, 32'd2);
        push_rd(32'h1C); push_wb(5'd10, 32'd5);
        push_rd(32'h20);
`ifdef CTRL_BRANCH_EN
        push_rd(32'h30);
        push_rd(32'h34);
`endif
        release_reset();
        run_to_trap(200);
        chk("add_wb_cycle", first_wb_cyc, 4);

        // LW with three wait states in MEM, then an all-zero (illegal) word
        enter_reset();
        memarr.delete();
        memarr[32'h00] = 32'h00802283;  // LW x5,8(x0)
        memarr[32'h04] = 32'h00000000;
        memarr[32'h08] = 32'hDEADBEEF;
        slow_addr = 32'h8;
        push_rd(32'h00);
        push_rd(32'h08); push_wb(5'd5, 32'hDEADBEEF);
        push_rd(32'h04);
        release_reset();
        run_to_trap(200);
        chk("lw_wb_cycle", first_wb_cyc, 8);
        slow_addr = 32'hFFFF_FFFF;

        // Misaligned store traps without a data request
        enter_reset();
        chk("rst2_illegal", illegal, 0);
        memarr.delete();
        memarr[32'h00] = 32'h00302323;  // SW x3,6(x0)
        push_rd(32'h00);
        release_reset();
        run_to_trap(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port mem_req, output, 1 bit: memory request.
REQ-005 The block SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read.
REQ-006 The block SHALL have ports mem_addr and mem_wdata, outputs, 32 bits each: request address and store data.
REQ-007 The block SHALL have ports mem_rdata (input, 32 bits: read data) and mem_ack (input, 1 bit: one-cycle completion strobe).
REQ-008 The block SHALL have ports rs_1, rs_2 and rd_0, outputs, 5 bits each: register file addresses.
REQ-009 The block SHALL have port immediate, output, 32 bits: sign-extended immediate.
REQ-010 The block SHALL have port alu_source, output, 1 bit: 1 = rs2, 0 = immediate.
REQ-011 The block SHALL have port alu_control, output, 3 bits: ALU operation.
REQ-012 The block SHALL have ports write_rb (output, 1 bit: register write enable) and writedata (output, 32 bits: register write data).
REQ-013 The block SHALL have ports alu_result and rs2_data, inputs, 32 bits each: ALU output and register read port 2.
REQ-014 The block SHALL have ports negative, overflow and zero, inputs, 1 bit each: ALU status flags.
REQ-015 The block SHALL have port illegal, output, 1 bit: sticky trap indicator.

Function
REQ-016 The block SHALL implement states FETCH, DECODE, EXECUTE, MEM, WB and TRAP; all outputs are registered or decoded from registered state and the instruction register (IR) only.
REQ-017 alu_control encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
REQ-018 In FETCH the block SHALL hold mem_req=1, mem_we=0, mem_addr=PC until mem_ack=1, then latch mem_rdata into IR and go to DECODE.
REQ-019 From DECODE onward the block SHALL drive rs_1=IR[19:15], rs_2=IR[24:20], rd_0=IR[11:7] and the I/S/B/U-format immediate.
REQ-020 In DECODE an unsupported opcode, funct3 or funct7 SHALL go to TRAP; otherwise the block SHALL go to EXECUTE.
REQ-021 Supported instructions SHALL be: R-type ADD/SUB/AND/OR/XOR/SLT/SLL/SRL; ADDI/ANDI/ORI/XORI/SLTI; LW; SW; LUI (rs_1 forced to 0, ADD); and BEQ/BNE when CTRL_BRANCH_EN is defined.
REQ-022 EXECUTE SHALL last one cycle and latch alu_result into ALUOUT; R/I/LUI go to WB, LW/SW go to MEM.
REQ-023 In EXECUTE, LW/SW with ALUOUT[1:0]!=0 SHALL go to TRAP without issuing a memory request.
REQ-024 In MEM the block SHALL drive mem_req=1 and mem_addr=ALUOUT; for SW it SHALL also drive mem_we=1 and mem_wdata=rs2_data.
REQ-025 MEM SHALL hold until mem_ack=1; SW then sets PC<=PC+4 and goes to FETCH, LW latches mem_rdata and goes to WB.
REQ-026 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable while mem_req=1 and mem_ack=0.
REQ-027 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-028 WB SHALL assert write_rb for exactly one cycle with writedata = load data (LW) or ALUOUT (all others).
REQ-029 WB SHALL keep write_rb=0 when rd_0=0, set PC<=PC+4, and go to FETCH.
REQ-030 write_rb SHALL be 0 in every state other than WB.
REQ-031 PC arithmetic SHALL wrap modulo 2^32.
REQ-032 With a zero-wait-state memory (ack the cycle after req), cycles per instruction SHALL be: R/I/LUI 4, LW 5, SW 4, branch 3.
REQ-033 TRAP SHALL deassert mem_req and write_rb, set illegal=1, and remain until reset.

Reset
REQ-034 While rst_n=0 the block SHALL immediately force state=FETCH, PC=RESET_PC, IR=0, illegal=0 and all outputs to 0, including dropping an in-flight mem_req.
REQ-035 mem_req SHALL first assert on the first rising clk edge after rst_n deasserts; any mem_ack arriving before that SHALL be ignored.

Configuration
REQ-036 With CTRL_BRANCH_EN defined, BEQ/BNE SHALL use SUB in EXECUTE and then go to FETCH with PC<=PC+imm when (BEQ and zero=1) or (BNE and zero=0), else PC<=PC+4.
REQ-037 Without CTRL_BRANCH_EN, opcode 1100011 SHALL be illegal and go to TRAP.

Verification
REQ-038 ADD x3,x1,x2 (32'h002081B3), zero-wait memory -> write_rb=1 in cycle 4 with rd_0=3, writedata=alu_result; next fetch address 0x4.
REQ-039 LW x5,8(x0), mem_ack delayed 3 cycles in MEM -> mem_addr=0x8 held stable; write_rb=1 with writedata=mem_rdata=32'hDEADBEEF.
REQ-040 SW to address 0x6 -> TRAP, illegal=1, no MEM request issued, mem_req stays 0 thereafter.
REQ-041 BEQ +16 at PC=0x20 with zero=1 -> next fetch address 0x30; with zero=0 -> next fetch address 0x24; macro undefined -> TRAP.
REQ-042 rst_n pulsed low during a FETCH wait -> mem_req=0 immediately; after release, fetch restarts at RESET_PC.
